mem_sequencer: RTL
==================

# mem_sequencer

Multi-cycle memory sequencer between the single-cycle datapath and a single-port, variable-latency memory. It fetches the instruction at `pc` and latches it, then performs at most one load or store for that instruction. It then pulses `step` for one cycle so the datapath commits the PC and register-file writes. It owns the shared memory port, replacing the direct instruction/data tie-off on the datapath's `ReadData`.

## Interface
- `ADDR_W`, 32, width of `pc`, `ALUResult` and `mem_addr`
- `DATA_W`, 32, width of instruction, data and memory words
- `NOP_INSTR`, 32'h00000013, value held on `instr` after reset (`addi x0,x0,0`)

- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: asynchronous, active-low (asserted at 0)
- `pc` in ADDR_W: fetch address from the datapath PC register
- `ALUResult` in ADDR_W: load/store address
- `WriteData` in DATA_W: store data
- `MemRead` in 1: decoded load; valid during DECODE
- `MemWrite` in 1: decoded store; valid during DECODE
- `instr` out DATA_W: latched instruction, drives decode and the register-file address fields
- `ReadData` out DATA_W: latched load data for the result mux
- `step` out 1: one-cycle commit enable; the datapath PC register and `RegWrite` are qualified by it
- `mem_req` out 1: memory request valid
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req`=1
- `mem_addr` out ADDR_W: request address
- `mem_wdata` out DATA_W: write data
- `mem_ready` in 1: memory completes the request in this cycle
- `mem_rdata` in DATA_W: read data, valid when `mem_ready`=1 on a read

## Operation
- States: IDLE, FETCH, DECODE, DATA, COMMIT.
- Reset behaviour (`reset`=0):
  - state goes to IDLE.
  - `instr`=NOP_INSTR, `ReadData`=0, `step`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- IDLE: always moves to FETCH on the next edge.
- FETCH:
  - drives `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`.
  - On an edge with `mem_ready`=1, captures `mem_rdata` into `instr` and goes to DECODE; otherwise stays in FETCH.
- DECODE: no request. Samples `MemWrite`/`MemRead`.
  - Either one set: go to DATA.
  - Neither set: go to COMMIT.
- DATA:
  - drives `mem_req`=1, `mem_addr`=`ALUResult`, `mem_we`=`MemWrite`, `mem_wdata`=`WriteData`.
  - On `mem_ready`=1 the state goes to COMMIT.
  - If it was a read, `mem_rdata` is captured into `ReadData` at that edge.
- Both `MemWrite` and `MemRead` set: treated as a write; `ReadData` is unchanged.
- COMMIT: `step`=1 for exactly this cycle, then go to FETCH.
- `ReadData` holds the last completed load value until the next load completes. `instr` holds until the next fetch completes.
- When `mem_req`=0, `mem_we`, `mem_addr` and `mem_wdata` are driven to 0. `mem_ready` is ignored.
- Addresses pass unmodified; no alignment check and no byte strobes.

## Timing
- Handshake:
  - a transfer completes on the edge where `mem_req`=1 and `mem_ready`=1.
  - While `mem_req`=1 and `mem_ready`=0, `mem_we`, `mem_addr` and `mem_wdata` hold stable.
  - `mem_req` never drops before completion, except on reset.
- Zero-wait memory (`mem_ready` high in the request cycle) means each access costs 1 cycle.
- Latency with zero wait states:
  - non-memory instruction: 3 cycles (FETCH, DECODE, COMMIT).
  - load/store: 4 cycles.
  - each wait state adds 1 cycle.
- First `mem_req` is asserted in the 2nd cycle after `reset` deasserts (the IDLE cycle comes first).
- `step` is high for exactly one cycle per instruction. It is never high in consecutive cycles.
- `pc`, `ALUResult`, `WriteData`, `MemRead` and `MemWrite` must remain stable from DECODE through COMMIT. The datapath guarantees this because the PC only updates on `step`.
- Reset during FETCH or DATA: `mem_req` drops asynchronously and the transfer is abandoned. The memory must tolerate this. No `step` is issued.

## Test plan
- Reset then zero-wait memory; `pc`=0, `mem_rdata`=32'h00500093 (`addi`), `MemRead`=`MemWrite`=0:
  - `mem_req` first high in cycle 2 with `mem_addr`=0.
  - `instr`=32'h00500093 from DECODE on.
  - `step` high in cycle 4 only.
- Load with 3 wait states on data: `ALUResult`=32'h100, `mem_rdata`=32'hDEADBEEF:
  - `mem_addr`=32'h100 and `mem_we`=0, held for 4 cycles.
  - `ReadData`=32'hDEADBEEF.
  - `step` comes 1 cycle after completion.
- Store, `ALUResult`=32'h200, `WriteData`=32'h12345678, 2 wait states:
  - `mem_we`=1 with address and data stable for 3 cycles.
  - `ReadData` unchanged.
  - exactly one `step`.
- Fetch stall, `mem_ready` low for 5 cycles:
  - `mem_addr`=`pc` stable.
  - `instr` keeps its prior value.
  - no `step` until after completion.
- `reset` pulsed low mid-DATA:
  - `mem_req`=0 and `instr`=32'h00000013 immediately.
  - no `step`.
  - restart from IDLE gives the first request 2 cycles after release.
- `MemRead`=`MemWrite`=1 → `mem_we`=1 and `ReadData` unchanged. `mem_ready` pulsed during DECODE/COMMIT → ignored.

Source files
------------

// File: rtl/mem_sequencer_if.sv
// Shared single-port memory bus between the sequencer (master) and the memory (slave).
// Valid/ready handshake: a transfer completes on the edge where mem_req and mem_ready are both high.
interface mem_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/mem_sequencer.sv
// Fetch, optional load/store, then a one-cycle commit pulse; 3 cycles per non-memory instruction, 4 per load/store.
// Each memory wait state stretches the request by one cycle with address, write flag and data held.
module mem_sequencer #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              MemRead,
   input  logic              MemWrite,
   output logic [DATA_W-1:0] instr,
   output logic [DATA_W-1:0] ReadData,
   output logic              step,
   mem_sequencer_if.master   mem
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] DATA   = 3'd3;
   localparam logic [2:0] COMMIT = 3'd4;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic       is_wr;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (mem.mem_ready) state_nxt = DECODE;
         DECODE:  state_nxt = (MemRead || MemWrite) ? DATA : COMMIT;
         DATA:    if (mem.mem_ready) state_nxt = COMMIT;
         COMMIT:  state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   // A request with both MemRead and MemWrite set is a store; the flag is
   // latched so mem_we cannot glitch while the memory is stalling.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         instr    <= NOP_INSTR;
         ReadData <= '0;
         is_wr    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == FETCH && mem.mem_ready)
            instr <= mem.mem_rdata;
         if (state == DECODE)
            is_wr <= MemWrite;
         if (state == DATA && mem.mem_ready && !is_wr)
            ReadData <= mem.mem_rdata;
      end
   end

   // Bus outputs decode straight from state so an async reset drops mem_req at once.
   always_comb begin
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      step          = (state == COMMIT);
      case (state)
         FETCH: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = pc;
         end
         DATA: begin
            mem.mem_req   = 1'b1;
            mem.mem_we    = is_wr;
            mem.mem_addr  = ALUResult;
            mem.mem_wdata = WriteData;
         end
         default: ;
      endcase
   end

endmodule
